// File: rtl/clint_pkg.sv
// Shared definitions for the core-local interruptor (CLINT): register map
// offsets, reset constants, bus FSM states and the mip bit positions the
// CLINT outputs feed.
package clint_pkg;

    // mtimecmp comes out of reset at its maximum so no timer interrupt fires
    localparam logic [63:0] MTIMECMP_RST = 64'hFFFF_FFFF_FFFF_FFFF;

    // Byte offsets of the registers inside the CLINT window
    typedef enum logic [15:0] {
        MSIP_OFF        = 16'h0000,
        MTIMECMP_LO_OFF = 16'h4000,
        MTIMECMP_HI_OFF = 16'h4004,
        MTIME_LO_OFF    = 16'hBFF8,
        MTIME_HI_OFF    = 16'hBFFC
    } clint_offset_e;

    // Bus-side request/response sequencing
    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RESP = 1'b1
    } clint_state_e;

    // Bit positions in the core's mip CSR
    typedef enum logic [4:0] {
        MIP_MSIP = 5'd3,
        MIP_MTIP = 5'd7,
        MIP_MEIP = 5'd11
    } mip_field_e;

    // Merge a 32-bit write into an existing word honouring byte enables
    function automatic logic [31:0] be_merge(input logic [31:0] old_val,
                                             input logic [31:0] wdata,
                                             input logic [3:0]  be);
        logic [31:0] res;
        res = old_val;
        for (int i = 0; i < 4; i++) begin
            if (be[i]) begin
                res[i*8 +: 8] = wdata[i*8 +: 8];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/clint_timer.sv
// clint_timer: prescaler and 64-bit mtime counter. A software write to
// either half takes priority over a coincident tick (no increment that
// cycle) and restarts the prescaler.
module clint_timer
    import clint_pkg::*;
#(
    parameter int PRESCALE = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_wr_lo,
    input  logic        i_wr_hi,
    input  logic [31:0] i_wdata,
    input  logic [3:0]  i_be,
    output logic [63:0] o_mtime,
    output logic        o_tick
);

    localparam int              PRE_W   = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(PRESCALE - 1);

    logic [PRE_W-1:0] r_pre;
    logic [63:0]      r_mtime;
    logic             w_tick;

    assign w_tick  = (r_pre == PRE_MAX);
    assign o_tick  = w_tick;
    assign o_mtime = r_mtime;

    // Prescaler and mtime update: write beats tick, tick wraps the prescaler
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pre   <= '0;
            r_mtime <= 64'd0;
        end else if (i_wr_lo || i_wr_hi) begin
            r_pre <= '0;
            if (i_wr_lo) begin
                r_mtime[31:0] <= be_merge(r_mtime[31:0], i_wdata, i_be);
            end
            if (i_wr_hi) begin
                r_mtime[63:32] <= be_merge(r_mtime[63:32], i_wdata, i_be);
            end
        end else if (w_tick) begin
            r_pre   <= '0;
            r_mtime <= r_mtime + 64'd1;
        end else begin
            r_pre <= r_pre + PRE_W'(1);
        end
    end

endmodule

// File: rtl/core_clint.sv
// core_clint: memory-mapped msip / mtime / mtimecmp block driving the
// core's MSIP and MTIP interrupt inputs. One outstanding response; a new
// request can be accepted in the same cycle the pending response drains.
// Optional build macro CLINT_HI_LATCH_EN: a read of mtime[31:0] snapshots
// mtime[63:32] so the following read of 0xBFFC is tear-free.
module core_clint
    import clint_pkg::*;
#(
    parameter int ADDR_W   = 16,
    parameter int PRESCALE = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [3:0]        req_be,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err,
    output logic              msip_o,
    output logic              mtip_o
);

    clint_state_e r_state;
    logic         r_rsp_valid;
    logic [31:0]  r_rdata;
    logic         r_err;
    logic         r_msip;
    logic [63:0]  r_mtimecmp;
    logic         r_cmp_dirty;
    logic         r_mtip;

    logic         w_sel_msip, w_sel_cmp_lo, w_sel_cmp_hi, w_sel_mt_lo, w_sel_mt_hi;
    logic         w_err;
    logic [31:0]  w_rd;
    logic [31:0]  w_mtime_hi_rd;
    logic         w_accept, w_wr;
    logic [63:0]  w_mtime;
    logic         w_tick;

    assign req_ready = (r_state == ST_IDLE) || rsp_ready;
    assign w_accept  = req_valid && req_ready;
    assign w_wr      = w_accept && req_we;

    assign rsp_valid = r_rsp_valid;
    assign rsp_rdata = r_rdata;
    assign rsp_err   = r_err;
    assign msip_o    = r_msip;
    assign mtip_o    = r_mtip;

    // Address decode and read mux; misaligned offsets never match a map entry
    always_comb begin
        w_sel_msip   = 1'b0;
        w_sel_cmp_lo = 1'b0;
        w_sel_cmp_hi = 1'b0;
        w_sel_mt_lo  = 1'b0;
        w_sel_mt_hi  = 1'b0;
        w_err        = 1'b0;
        w_rd         = 32'd0;
        case (req_addr)
            ADDR_W'(MSIP_OFF): begin
                w_sel_msip = 1'b1;
                w_rd       = {31'd0, r_msip};
            end
            ADDR_W'(MTIMECMP_LO_OFF): begin
                w_sel_cmp_lo = 1'b1;
                w_rd         = r_mtimecmp[31:0];
            end
            ADDR_W'(MTIMECMP_HI_OFF): begin
                w_sel_cmp_hi = 1'b1;
                w_rd         = r_mtimecmp[63:32];
            end
            ADDR_W'(MTIME_LO_OFF): begin
                w_sel_mt_lo = 1'b1;
                w_rd        = w_mtime[31:0];
            end
            ADDR_W'(MTIME_HI_OFF): begin
                w_sel_mt_hi = 1'b1;
                w_rd        = w_mtime_hi_rd;
            end
            default: begin
                w_err = 1'b1;
            end
        endcase
    end

    clint_timer #(
        .PRESCALE (PRESCALE)
    ) u_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_wr_lo (w_wr && w_sel_mt_lo),
        .i_wr_hi (w_wr && w_sel_mt_hi),
        .i_wdata (req_wdata),
        .i_be    (req_be),
        .o_mtime (w_mtime),
        .o_tick  (w_tick)
    );

`ifdef CLINT_HI_LATCH_EN
    logic [31:0] r_shadow;

    // Snapshot the upper mtime half whenever the lower half is read
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_shadow <= 32'd0;
        end else if (w_accept && !req_we && w_sel_mt_lo) begin
            r_shadow <= w_mtime[63:32];
        end
    end

    assign w_mtime_hi_rd = r_shadow;
`else
    assign w_mtime_hi_rd = w_mtime[63:32];
`endif

    // Software-visible msip and mtimecmp registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_msip     <= 1'b0;
            r_mtimecmp <= MTIMECMP_RST;
        end else begin
            if (w_wr && w_sel_msip && req_be[0]) begin
                r_msip <= req_wdata[0];
            end
            if (w_wr && w_sel_cmp_lo) begin
                r_mtimecmp[31:0] <= be_merge(r_mtimecmp[31:0], req_wdata, req_be);
            end
            if (w_wr && w_sel_cmp_hi) begin
                r_mtimecmp[63:32] <= be_merge(r_mtimecmp[63:32], req_wdata, req_be);
            end
        end
    end

    // Timer interrupt: re-evaluate the compare the cycle after mtime or mtimecmp may have moved
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cmp_dirty <= 1'b0;
            r_mtip      <= 1'b0;
        end else begin
            r_cmp_dirty <= w_tick || (w_wr && (w_sel_cmp_lo || w_sel_cmp_hi ||
                                               w_sel_mt_lo  || w_sel_mt_hi));
            if (r_cmp_dirty) begin
                r_mtip <= (w_mtime >= r_mtimecmp);
            end
        end
    end

    // Request/response FSM with registered response fields
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_rsp_valid <= 1'b0;
            r_rdata     <= 32'd0;
            r_err       <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (req_valid) begin
                        r_state     <= ST_RESP;
                        r_rsp_valid <= 1'b1;
                        r_rdata     <= req_we ? 32'd0 : w_rd;
                        r_err       <= w_err;
                    end
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        if (req_valid) begin
                            r_rsp_valid <= 1'b1;
                            r_rdata     <= req_we ? 32'd0 : w_rd;
                            r_err       <= w_err;
                        end else begin
                            r_state     <= ST_IDLE;
                            r_rsp_valid <= 1'b0;
                            r_rdata     <= 32'd0;
                            r_err       <= 1'b0;
                        end
                    end
                end
                default: begin
                    r_state     <= ST_IDLE;
                    r_rsp_valid <= 1'b0;
                    r_rdata     <= 32'd0;
                    r_err       <= 1'b0;
                end
            endcase
        end
    end

endmodule
